adc_sine_meas: RTL and testbench

Receive-side measurement block for the sine generator path: consumes 10-bit offset-binary ADC samples of the generated waveform and reports its frequency in 100 Hz steps and its peak-to-peak amplitude in 0.1 V steps. The output widths match the generator's frequency index (1–30) and amplitude setting (10–20), so the seven-segment display can show the generator setting and the loop-back measurement side by side. It sits in the `clk_50m` domain, downstream of the ADC capture register.

---
 rtl/adc_sine_meas.sv | 166 ++++++++++++++++
 tb/tb_adc_sine_meas.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/adc_sine_meas.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_sine_meas: frequency (100 Hz steps) and Vpp (0.1 V steps) of ADC sine |
// | Optional: MEAS_ROUND_EN selects round-to-nearest division. Rev 1.0        |
// +--------------------------------------------------------------------------+
module adc_sine_meas #(
  parameter int GATE_CYCLES     = 5_000_000,
  parameter int MID_CODE        = 512,
  parameter int HYST            = 16,
  parameter int CODES_PER_100MV = 20,
  parameter int FREQ_DIV        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] ad_data,
  input  logic       ad_valid,
  output logic [4:0] freq,
  output logic [4:0] value,
  output logic [9:0] vpp,
  output logic       meas_done
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [10:0]   LO_TH     = 11'(MID_CODE - HYST);
  localparam logic [10:0]   HI_TH     = 11'(MID_CODE + HYST);
  localparam logic [16:0]   F_DIV     = 17'(FREQ_DIV);
  localparam logic [10:0]   A_DIV     = 11'(CODES_PER_100MV);
`ifdef MEAS_ROUND_EN
  localparam logic [16:0]   F_BIAS    = 17'(FREQ_DIV / 2);
  localparam logic [10:0]   A_BIAS    = 11'(CODES_PER_100MV / 2);
`else
  localparam logic [16:0]   F_BIAS    = 17'd0;
  localparam logic [10:0]   A_BIAS    = 11'd0;
`endif

  typedef enum logic [1:0] {
    ST_GATE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gate_cnt;
  logic [4:0]      calc_cnt;
  logic [9:0]      max_code, min_code, vpp_l;
  logic            arm;
  logic [15:0]     cnt;
  logic [16:0]     f_rem;
  logic [10:0]     a_rem;
  logic [4:0]      f_quo, a_quo;

  logic            gate_last, calc_last, accept;
  logic [9:0]      max_nxt, min_nxt, vpp_nxt;
  logic            arm_nxt;
  logic [15:0]     cnt_nxt;
  logic            f_step, a_step;
  logic [4:0]      f_quo_nxt, a_quo_nxt;

  assign gate_last = (state == ST_GATE) && (gate_cnt == GATE_LAST);
  assign calc_last = (state == ST_CALC) && (calc_cnt == 5'd31);
  assign accept    = (state == ST_GATE) && ad_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_GATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_GATE: if (gate_last) state_nxt = ST_CALC;
      ST_CALC: if (calc_last) state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_GATE;
      default: state_nxt = ST_GATE;
    endcase
  end

  // Sample bookkeeping as seen after the current sample, so the last gate
  // cycle's sample is folded into the latched results.
  always_comb begin
    max_nxt = max_code;
    min_nxt = min_code;
    arm_nxt = arm;
    cnt_nxt = cnt;
    if (accept) begin
      if (ad_data > max_code) max_nxt = ad_data;
      if (ad_data < min_code) min_nxt = ad_data;
      if ({1'b0, ad_data} < LO_TH) begin
        arm_nxt = 1'b1;
      end else if (({1'b0, ad_data} >= HI_TH) && arm) begin
        arm_nxt = 1'b0;
        if (cnt != 16'hFFFF) cnt_nxt = cnt + 16'd1;
      end
    end
    vpp_nxt = (max_nxt >= min_nxt) ? (max_nxt - min_nxt) : 10'd0;
  end

  assign f_step    = (f_rem >= F_DIV) && (f_quo != 5'd31);
  assign a_step    = (a_rem >= A_DIV) && (a_quo != 5'd31);
  assign f_quo_nxt = f_step ? f_quo + 5'd1 : f_quo;
  assign a_quo_nxt = a_step ? a_quo + 5'd1 : a_quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt  <= '0;
      calc_cnt  <= '0;
      max_code  <= 10'd0;
      min_code  <= 10'd1023;
      arm       <= 1'b0;
      cnt       <= 16'd0;
      vpp_l     <= 10'd0;
      f_rem     <= '0;
      a_rem     <= '0;
      f_quo     <= '0;
      a_quo     <= '0;
      freq      <= '0;
      value     <= '0;
      vpp       <= '0;
      meas_done <= 1'b0;
    end else begin
      meas_done <= 1'b0;
      case (state)
        ST_GATE: begin
          gate_cnt <= gate_last ? '0 : gate_cnt + 1'b1;
          max_code <= max_nxt;
          min_code <= min_nxt;
          arm      <= arm_nxt;
          cnt      <= cnt_nxt;
          if (gate_last) begin
            vpp_l    <= vpp_nxt;
            f_rem    <= {1'b0, cnt_nxt} + F_BIAS;
            a_rem    <= {1'b0, vpp_nxt} + A_BIAS;
            f_quo    <= '0;
            a_quo    <= '0;
            calc_cnt <= '0;
          end
        end
        ST_CALC: begin
          calc_cnt <= calc_cnt + 5'd1;
          f_quo    <= f_quo_nxt;
          a_quo    <= a_quo_nxt;
          if (f_step) f_rem <= f_rem - F_DIV;
          if (a_step) a_rem <= a_rem - A_DIV;
          // Results land together with meas_done in the single OUT cycle.
          if (calc_last) begin
            freq      <= f_quo_nxt;
            value     <= a_quo_nxt;
            vpp       <= vpp_l;
            meas_done <= 1'b1;
          end
        end
        ST_OUT: begin
          gate_cnt <= '0;
          max_code <= 10'd0;
          min_code <= 10'd1023;
          arm      <= 1'b0;
          cnt      <= 16'd0;
        end
        default: gate_cnt <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_sine_meas.sv
`default_nettype none
// Scoreboard bench for adc_sine_meas: random gate windows against an arithmetic model.
module tb_adc_sine_meas;

  localparam int G      = 1000;
  localparam int PERIOD = G + 33;
  localparam int MID    = 512;
  localparam int HY     = 16;
`ifdef MEAS_ROUND_EN
  localparam int FB = 5;
  localparam int AB = 10;
`else
  localparam int FB = 0;
  localparam int AB = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] ad_data = '0;
  logic       ad_valid = 1'b0;
  logic [4:0] freq, value;
  logic [9:0] vpp;
  logic       meas_done;

  adc_sine_meas #(
    .GATE_CYCLES(G), .MID_CODE(MID), .HYST(HY), .CODES_PER_100MV(20), .FREQ_DIV(10)
  ) dut (
    .clk(clk), .rst(rst), .ad_data(ad_data), .ad_valid(ad_valid),
    .freq(freq), .value(value), .vpp(vpp), .meas_done(meas_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int f; int v; int p; } exp_t;
  exp_t q[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   hf = 0, hv = 0, hp = 0;
  bit   started = 1'b0;

  function automatic int sat31(input int x);
    return (x > 31) ? 31 : x;
  endfunction

  task automatic model(input int s[$], input int base);
    int arm = 0, cnt = 0, mx = 0, mn = 1023, p;
    exp_t x;
    foreach (s[i]) begin
      if (s[i] < MID - HY) arm = 1;
      else if (s[i] >= MID + HY && arm == 1) begin
        arm = 0;
        if (cnt < 65535) cnt++;
      end
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    p   = (s.size() > 0) ? mx - mn : 0;
    x.c = base + G + 32;
    x.f = sat31((cnt + FB) / 10);
    x.v = sat31((p + AB) / 20);
    x.p = p;
    q.push_back(x);
  endtask

  task automatic gen(input int mode, input int k, output logic v, output logic [9:0] d);
    v = 1'b1;
    d = 10'($urandom_range(0, 1023));
    case (mode)
      0: d = ((k / 50) % 2 == 1) ? 10'd624 : 10'd400;
      1: d = (k % 4 < 2) ? 10'd300 : 10'd724;
      2: d = (k % 2 == 1) ? 10'd1023 : 10'd0;
      3: d = (k % 2 == 1) ? 10'd519 : 10'd505;
      4: v = 1'b0;
      default: v = 1'($urandom_range(0, 1));
    endcase
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      if (q.size() > 0 && q[0].c < cyc) begin
        checks++; errors++;
        $display("FAIL missed_meas_done expected at cycle %0d, now %0d", q[0].c, cyc);
        void'(q.pop_front());
      end
      if (meas_done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_meas_done at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          if (e.c != cyc || freq !== 5'(e.f) || value !== 5'(e.v) || vpp !== 10'(e.p)) begin
            errors++;
            $display("FAIL result got cyc=%0d freq=%0d value=%0d vpp=%0d want cyc=%0d freq=%0d value=%0d vpp=%0d",
                     cyc, freq, value, vpp, e.c, e.f, e.v, e.p);
          end
          hf = e.f; hv = e.v; hp = e.p;
        end
      end
      checks++;
      if (freq !== 5'(hf) || value !== 5'(hv) || vpp !== 10'(hp)) begin
        errors++;
        $display("FAIL hold at cycle %0d got freq=%0d value=%0d vpp=%0d want %0d %0d %0d",
                 cyc, freq, value, vpp, hf, hv, hp);
      end
    end
  end

  initial begin
    int         samples[$];
    int         mode, base;
    logic       v;
    logic [9:0] d;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (freq !== 5'd0 || value !== 5'd0 || vpp !== 10'd0 || meas_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got freq=%0d value=%0d vpp=%0d done=%0b want all 0",
               freq, value, vpp, meas_done);
    end
    started = 1'b1;
    for (int w = 0; w < 14; w++) begin
      mode = (w < 6) ? w : int'($urandom_range(0, 5));
      base = cyc;
      samples.delete();
      for (int k = 0; k < PERIOD; k++) begin
        gen(mode, k, v, d);
        ad_valid = v;
        ad_data  = d;
        if (w == 7 && k == 400) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          rst = 1'b0;
          hf = 0; hv = 0; hp = 0;
          checks++;
          if (freq !== 5'd0 || value !== 5'd0 || vpp !== 10'd0 || meas_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got freq=%0d value=%0d vpp=%0d done=%0b want all 0",
                     freq, value, vpp, meas_done);
          end
          break;
        end
        if (k < G && v) samples.push_back(int'(d));
        if (k == G - 1) model(samples, base);
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d outstanding want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
